// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the N x N, K-in-a-row board game.
//   - cell encodings EMPTY / P1 / P2 (2 bits per cell)
//   - controller FSM state enum and scan direction enum
//   - small helpers for player toggling and direction sequencing
package game_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TURN  = 2'b01,
    ST_CHECK = 2'b10,
    ST_END   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DIR_H = 2'b00,  // along a row
    DIR_V = 2'b01,  // along a column
    DIR_D = 2'b10,  // x and y both increasing
    DIR_A = 2'b11   // x increasing while y decreases
  } dir_e;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction

  function automatic dir_e next_dir(input dir_e d);
    dir_e r;
    case (d)
      DIR_H:   r = DIR_V;
      DIR_V:   r = DIR_D;
      DIR_D:   r = DIR_A;
      DIR_A:   r = DIR_H;
      default: r = DIR_H;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/line_scanner.sv
// line_scanner: combinational run-length counter for one direction.
// Counts the cell at (x, y) plus contiguous cells owned by `player` on
// both sides along `dir`, at most K-1 per side, stopping at the board edge
// (no wrap between rows). The result saturates at K.
//   board   in  2*N*N  row-major, cell (0,0) in the MSBs
//   x, y    in  CW     column / row of the centre cell
//   dir     in  dir_e  direction to scan
//   player  in  2      owner to match
//   run_len out RW     min(K, run length)
module line_scanner
  import game_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int CW = 2,
  parameter int RW = $clog2(K + 1)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    y,
  input  dir_e             dir,
  input  logic [1:0]       player,
  output logic [RW-1:0]    run_len
);

  int   dx;
  int   dy;
  int   fwd;
  int   bwd;
  int   total;
  logic fwd_stop;
  logic bwd_stop;

  // Off-board coordinates read as EMPTY, which never matches a player.
  function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int cx, input int cy);
    logic [1:0] c;
    if (cx >= 0 && cx < N && cy >= 0 && cy < N) begin
      c = b[2*(N*N-1-(cy*N+cx)) +: 2];
    end else begin
      c = EMPTY;
    end
    return c;
  endfunction

  // Step vector for the selected direction.
  always_comb begin
    case (dir)
      DIR_H:   begin dx = 1; dy = 0;  end
      DIR_V:   begin dx = 0; dy = 1;  end
      DIR_D:   begin dx = 1; dy = 1;  end
      DIR_A:   begin dx = 1; dy = -1; end
      default: begin dx = 1; dy = 0;  end
    endcase
  end

  // Walk outwards on both sides; the first mismatch ends that side.
  always_comb begin
    fwd      = 0;
    bwd      = 0;
    fwd_stop = 1'b0;
    bwd_stop = 1'b0;
    for (int s = 1; s < K; s++) begin
      if (!fwd_stop && cell_at(board, int'(x) + s*dx, int'(y) + s*dy) == player) begin
        fwd = fwd + 1;
      end else begin
        fwd_stop = 1'b1;
      end
      if (!bwd_stop && cell_at(board, int'(x) - s*dx, int'(y) - s*dy) == player) begin
        bwd = bwd + 1;
      end else begin
        bwd_stop = 1'b1;
      end
    end
    total = 1 + fwd + bwd;
    if (total >= K) begin
      run_len = RW'(K);
    end else begin
      run_len = RW'(total);
    end
  end

endmodule

// File: rtl/board_game_nk.sv
// board_game_nk: two-player N x N board game controller, K in a row wins.
// A legal move is written in TURN, then four CHECK cycles scan the row,
// column, diagonal and anti-diagonal through the new stone using a single
// time-multiplexed line_scanner.
//   clk, rst_n          clock, async active-low reset
//   x_in, y_in   in CW  column / row of the requested move
//   make_move    in 1   move request
//   first_player in 2   starting player, sampled on IDLE -> TURN
//   new_game     in 1   synchronous restart, highest priority
//   move_ack     out 1  pulse: move accepted
//   move_err     out 1  pulse: move rejected
//   busy         out 1  high during CHECK
//   turn         out 2  player to move, 00 outside TURN
//   winner       out 2  00 none, 01 P1, 10 P2
//   tie          out 1  board full with no winner
//   board        out 2*N*N  row-major, cell (0,0) in the MSBs
module board_game_nk
  import game_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int K  = 3,
  localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CW-1:0]     x_in,
  input  logic [CW-1:0]     y_in,
  input  logic              make_move,
  input  logic [1:0]        first_player,
  input  logic              new_game,
  output logic              move_ack,
  output logic              move_err,
  output logic              busy,
  output logic [1:0]        turn,
  output logic [1:0]        winner,
  output logic              tie,
  output logic [2*N*N-1:0]  board
);

  localparam int              CELLS = N * N;
  localparam int              CNTW  = $clog2(CELLS + 1);
  localparam int              RW    = $clog2(K + 1);
  localparam logic [CNTW-1:0] FULL  = CNTW'(CELLS);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [1:0]         player_q, player_d;
  logic [1:0]         turn_q, turn_d;
  logic [1:0]         winner_q, winner_d;
  logic               tie_q, tie_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]      lx_q, lx_d;
  logic [CW-1:0]      ly_q, ly_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               in_range;
  logic [1:0]         target_cell;
  logic               move_ok;
  logic [RW-1:0]      run_len;

  line_scanner #(
    .N  (N),
    .K  (K),
    .CW (CW),
    .RW (RW)
  ) u_scan (
    .board   (board_q),
    .x       (lx_q),
    .y       (ly_q),
    .dir     (dir_q),
    .player  (player_q),
    .run_len (run_len)
  );

  // Legality of the requested coordinates; the index is only formed when in range.
  always_comb begin
    in_range = (int'(x_in) < N) && (int'(y_in) < N);
    if (in_range) begin
      target_cell = board_q[2*(CELLS-1-(int'(y_in)*N + int'(x_in))) +: 2];
    end else begin
      target_cell = EMPTY;
    end
    move_ok = in_range && (target_cell == EMPTY);
  end

  // Next-state logic for the game controller.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    player_d = player_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    board_d  = board_q;
    cnt_d    = cnt_q;
    lx_d     = lx_q;
    ly_d     = ly_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    if (new_game) begin
      state_d  = ST_IDLE;
      dir_d    = DIR_H;
      player_d = EMPTY;
      winner_d = EMPTY;
      tie_d    = 1'b0;
      board_d  = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_TURN;
          player_d = (first_player == P2) ? P2 : P1;
          err_d    = make_move;
        end
        ST_TURN: begin
          if (make_move && move_ok) begin
            board_d[2*(CELLS-1-(int'(y_in)*N + int'(x_in))) +: 2] = player_q;
            cnt_d   = cnt_q + CNTW'(1);
            lx_d    = x_in;
            ly_d    = y_in;
            dir_d   = DIR_H;
            ack_d   = 1'b1;
            state_d = ST_CHECK;
          end else if (make_move) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_TURN;
          end
        end
        ST_CHECK: begin
          err_d = make_move;
          if (run_len >= RW'(K)) begin
            winner_d = player_q;
            state_d  = ST_END;
          end else if (dir_q == DIR_A) begin
            if (cnt_q == FULL) begin
              tie_d   = 1'b1;
              state_d = ST_END;
            end else begin
              player_d = other_player(player_q);
              state_d  = ST_TURN;
            end
          end else begin
            dir_d = next_dir(dir_q);
          end
        end
        ST_END: begin
          err_d = make_move;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // Outputs are registered from the next-state view so they line up with state_q.
    busy_d = (state_d == ST_CHECK);
    if (state_d == ST_TURN) begin
      turn_d = player_d;
    end else begin
      turn_d = EMPTY;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_H;
      player_q <= EMPTY;
      turn_q   <= EMPTY;
      winner_q <= EMPTY;
      tie_q    <= 1'b0;
      board_q  <= '0;
      cnt_q    <= '0;
      lx_q     <= '0;
      ly_q     <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      player_q <= player_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      board_q  <= board_d;
      cnt_q    <= cnt_d;
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign move_ack = ack_q;
  assign move_err = err_q;
  assign busy     = busy_q;
  assign turn     = turn_q;
  assign winner   = winner_q;
  assign tie      = tie_q;
  assign board    = board_q;

endmodule

// File: tb/tb_board_game_nk.sv
// Bench for board_game_nk: a 3x3/K=3 instance (a) and a 5x5/K=4 instance (b).
// Each move pushes the expected {move_ack, move_err} to a scoreboard queue;
// the entry is popped and compared one edge later.
module tb_board_game_nk;

  localparam logic [1:0] P1  = 2'b01;
  localparam logic [1:0] P2  = 2'b10;
  localparam logic [1:0] ACK = 2'b10;
  localparam logic [1:0] ERR = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  a_x = 2'd0, a_y = 2'd0, a_fp = P1;
  logic        a_mm = 1'b0, a_ng = 1'b0;
  logic        a_ack, a_err, a_busy, a_tie;
  logic [1:0]  a_turn, a_win;
  logic [17:0] a_board;

  logic [2:0]  b_x = 3'd0, b_y = 3'd0;
  logic [1:0]  b_fp = P1;
  logic        b_mm = 1'b0, b_ng = 1'b0;
  logic        b_ack, b_err, b_busy, b_tie;
  logic [1:0]  b_turn, b_win;
  logic [49:0] b_board;

  board_game_nk #(.N(3), .K(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .x_in(a_x), .y_in(a_y), .make_move(a_mm),
    .first_player(a_fp), .new_game(a_ng), .move_ack(a_ack), .move_err(a_err),
    .busy(a_busy), .turn(a_turn), .winner(a_win), .tie(a_tie), .board(a_board)
  );

  board_game_nk #(.N(5), .K(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .x_in(b_x), .y_in(b_y), .make_move(b_mm),
    .first_player(b_fp), .new_game(b_ng), .move_ack(b_ack), .move_err(b_err),
    .busy(b_busy), .turn(b_turn), .winner(b_win), .tie(b_tie), .board(b_board)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  sb_q[$];
  logic [17:0] exp_a = '0;
  logic [49:0] exp_b = '0;

  function automatic logic [17:0] put3(input logic [17:0] b, input int x, input int y, input logic [1:0] p);
    logic [17:0] r;
    r = b;
    r[2*(8-(y*3+x)) +: 2] = p;
    return r;
  endfunction

  function automatic logic [49:0] put5(input logic [49:0] b, input int x, input int y, input logic [1:0] p);
    logic [49:0] r;
    r = b;
    r[2*(24-(y*5+x)) +: 2] = p;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move_a(input int x, input int y, input logic [1:0] p, input logic [1:0] resp);
    logic [1:0] e;
    if (resp == ACK) begin
      n_cmp++;
      if (a_turn !== p) begin
        n_bad++;
        $display("FAIL a_turn_before_move(%0d,%0d) got %b want %b", x, y, a_turn, p);
      end
      exp_a = put3(exp_a, x, y, p);
    end
    a_x  = 2'(x);
    a_y  = 2'(y);
    a_mm = 1'b1;
    sb_q.push_back(resp);
    tick();
    a_mm = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if ({a_ack, a_err} !== e) begin
      n_bad++;
      $display("FAIL a_resp(%0d,%0d) ack/err got %b want %b", x, y, {a_ack, a_err}, e);
    end
    n_cmp++;
    if (a_board !== exp_a) begin
      n_bad++;
      $display("FAIL a_board_after(%0d,%0d) got %h want %h", x, y, a_board, exp_a);
    end
  endtask

  task automatic move_b(input int x, input int y, input logic [1:0] p, input logic [1:0] resp);
    logic [1:0] e;
    if (resp == ACK) begin
      n_cmp++;
      if (b_turn !== p) begin
        n_bad++;
        $display("FAIL b_turn_before_move(%0d,%0d) got %b want %b", x, y, b_turn, p);
      end
      exp_b = put5(exp_b, x, y, p);
    end
    b_x  = 3'(x);
    b_y  = 3'(y);
    b_mm = 1'b1;
    sb_q.push_back(resp);
    tick();
    b_mm = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if ({b_ack, b_err} !== e) begin
      n_bad++;
      $display("FAIL b_resp(%0d,%0d) ack/err got %b want %b", x, y, {b_ack, b_err}, e);
    end
    n_cmp++;
    if (b_board !== exp_b) begin
      n_bad++;
      $display("FAIL b_board_after(%0d,%0d) got %h want %h", x, y, b_board, exp_b);
    end
  endtask

  // Accepted move followed by the four check cycles.
  task automatic play_a(input int x, input int y, input logic [1:0] p);
    move_a(x, y, p, ACK);
    repeat (4) tick();
  endtask

  task automatic play_b(input int x, input int y, input logic [1:0] p);
    move_b(x, y, p, ACK);
    repeat (4) tick();
  endtask

  task automatic new_game_a(input logic [1:0] fp);
    a_fp = fp;
    a_ng = 1'b1;
    tick();
    a_ng = 1'b0;
    tick();
    exp_a = '0;
  endtask

  task automatic new_game_b(input logic [1:0] fp);
    b_fp = fp;
    b_ng = 1'b1;
    tick();
    b_ng = 1'b0;
    tick();
    exp_b = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_board, a_win, a_tie, a_turn, a_ack, a_err, a_busy} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_a outputs got %h want 0", {a_board, a_win, a_tie, a_turn, a_ack, a_err, a_busy});
    end
    n_cmp++;
    if ({b_board, b_win, b_tie, b_turn, b_ack, b_err, b_busy} !== 58'd0) begin
      n_bad++;
      $display("FAIL reset_b outputs got %h want 0", {b_board, b_win, b_tie, b_turn, b_ack, b_err, b_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (a_turn !== P1) begin
      n_bad++;
      $display("FAIL reset_release_turn got %b want %b", a_turn, P1);
    end
  endtask

  task automatic test_p1_win();
    new_game_a(P1);
    play_a(0, 0, P1);
    play_a(0, 1, P2);
    play_a(1, 0, P1);
    play_a(1, 1, P2);
    play_a(2, 0, P1);
    n_cmp++;
    if ({a_win, a_tie, a_turn} !== {P1, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL p1_win win/tie/turn got %b want %b", {a_win, a_tie, a_turn}, {P1, 1'b0, 2'b00});
    end
    move_a(2, 2, P2, ERR);
    tick();
    n_cmp++;
    if (a_win !== P1) begin
      n_bad++;
      $display("FAIL p1_win_hold got %b want %b", a_win, P1);
    end
  endtask

  task automatic test_errors();
    new_game_a(P1);
    move_a(1, 1, P1, ACK);
    n_cmp++;
    if (a_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_in_check got %b want 1", a_busy);
    end
    move_a(0, 0, P2, ERR);
    repeat (3) tick();
    move_a(1, 1, P2, ERR);
    move_a(3, 0, P2, ERR);
    n_cmp++;
    if (a_turn !== P2) begin
      n_bad++;
      $display("FAIL turn_after_errors got %b want %b", a_turn, P2);
    end
  endtask

  task automatic test_tie();
    new_game_a(P1);
    play_a(0, 0, P1);
    play_a(1, 0, P2);
    play_a(2, 0, P1);
    play_a(1, 1, P2);
    play_a(0, 1, P1);
    play_a(2, 1, P2);
    play_a(1, 2, P1);
    play_a(0, 2, P2);
    play_a(2, 2, P1);
    n_cmp++;
    if ({a_win, a_tie, a_turn} !== {2'b00, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL tie win/tie/turn got %b want %b", {a_win, a_tie, a_turn}, {2'b00, 1'b1, 2'b00});
    end
  endtask

  task automatic test_anti_diag_5();
    new_game_b(P1);
    play_b(0, 3, P1);
    play_b(0, 0, P2);
    play_b(1, 3, P1);
    play_b(2, 0, P2);
    play_b(2, 3, P1);
    play_b(4, 4, P2);
    play_b(4, 2, P1);  // would be a 4-run if rows wrapped into row 3
    n_cmp++;
    if (b_win !== 2'b00) begin
      n_bad++;
      $display("FAIL no_wrap_win got %b want 00", b_win);
    end
    play_b(3, 3, P2);
    play_b(2, 2, P1);
    play_b(0, 1, P2);
    play_b(3, 1, P1);
    play_b(4, 1, P2);
    play_b(4, 0, P1);
    n_cmp++;
    if ({b_win, b_tie} !== {P1, 1'b0}) begin
      n_bad++;
      $display("FAIL anti_diag_win win/tie got %b want %b", {b_win, b_tie}, {P1, 1'b0});
    end
  endtask

  task automatic test_new_game_mid_check();
    new_game_a(P1);
    move_a(0, 0, P1, ACK);
    tick();
    a_ng = 1'b1;
    a_fp = P2;
    tick();
    a_ng = 1'b0;
    exp_a = '0;
    n_cmp++;
    if ({a_board, a_turn, a_busy, a_win, a_tie} !== 24'd0) begin
      n_bad++;
      $display("FAIL mid_check_clear got %h want 0", {a_board, a_turn, a_busy, a_win, a_tie});
    end
    tick();
    n_cmp++;
    if (a_turn !== P2) begin
      n_bad++;
      $display("FAIL first_player_p2 turn got %b want %b", a_turn, P2);
    end
  endtask

  task automatic test_async_reset();
    move_a(1, 1, P2, ACK);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_board, a_win, a_tie, a_turn, a_ack, a_err, a_busy} !== 26'd0) begin
      n_bad++;
      $display("FAIL async_reset_a got %h want 0", {a_board, a_win, a_tie, a_turn, a_ack, a_err, a_busy});
    end
    n_cmp++;
    if ({b_board, b_win, b_busy} !== 53'd0) begin
      n_bad++;
      $display("FAIL async_reset_b got %h want 0", {b_board, b_win, b_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_a = '0;
    tick();
    n_cmp++;
    if (a_turn !== P2) begin
      n_bad++;
      $display("FAIL async_release_turn got %b want %b", a_turn, P2);
    end
  endtask

  initial begin
    test_reset();
    test_p1_win();
    test_errors();
    test_tie();
    test_anti_diag_5();
    test_new_game_mid_check();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_game_nk.md
BOARD_GAME_NK -- requirements
Module: board_game_nk

Interface
REQ-001 Parameter N, default 3, board side length; legal range 3..8.
REQ-002 Parameter K, default 3, run length needed to win; legal range 3..N.
REQ-003 Derived constant CW = max(1, clog2(N)), the coordinate width.
REQ-004 clk  in  1  the single clock; every flop updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-006 x_in, y_in  in  CW each  column and row of the requested move.
REQ-007 make_move  in  1  move request, sampled only in a TURN state.
REQ-008 first_player  in  2  01 or 10; sampled when the game starts.
REQ-009 new_game  in  1  synchronous restart request, honoured in any state.
REQ-010 move_ack  out  1  one-cycle pulse: move accepted.
REQ-011 move_err  out  1  one-cycle pulse: move rejected.
REQ-012 busy  out  1  high while in CHECK.
REQ-013 turn  out  2  player to move: 01 or 10; 00 outside TURN.
REQ-014 winner  out  2  00 none, 01 player 1, 10 player 2.
REQ-015 tie  out  1  board full with no winner.
REQ-016 board  out  2*N*N  row-major; cell (0,0) in the MSBs; each cell 00 empty, 01 P1, 10 P2.

Function
REQ-017 FSM states: IDLE, TURN, CHECK, END.
REQ-018 IDLE moves to TURN one cycle later; on that edge it loads turn from first_player (value 11 or 00 loads 01).
REQ-019 In TURN, make_move is accepted when x_in<N, y_in<N and the target cell is empty.
  - On acceptance: write the current player to the cell, pulse move_ack, increment the move counter (width clog2(N*N+1)), latch the coordinates, enter CHECK.
REQ-020 In TURN, make_move with an out-of-range coordinate or an occupied cell pulses move_err only; the board, turn and state are unchanged.
REQ-021 make_move in IDLE, CHECK or END pulses move_err and has no other effect.
REQ-022 CHECK lasts exactly 4 cycles, one direction per cycle, in the order horizontal, vertical, diagonal, anti-diagonal.
  - Each cycle counts the latched cell plus contiguous same-player cells on both sides, up to K-1 each side, without wrapping past the board edge.
REQ-023 A count of K or more latches winner = mover and the FSM goes to END after that cycle.
REQ-024 If no run reaches K and the move counter equals N*N, tie is set and the FSM goes to END; otherwise turn toggles and the FSM returns to TURN.
REQ-025 Latency: for a move accepted on edge T, winner/tie are valid and the next move can be accepted from edge T+5.
REQ-026 END holds board, winner and tie until new_game or reset.
REQ-027 new_game takes priority over every other input in the same cycle.
  - It clears board, winner, tie and the counter and enters IDLE, even mid-CHECK.
REQ-028 winner and tie are never both set.

Reset
REQ-029 rst_n low forces state to IDLE and drives the following outputs, regardless of clk:
  - board all 00, winner 00, tie 0, turn 00;
  - move_ack 0, move_err 0, busy 0, counter 0.
REQ-030 Release of rst_n takes effect at the first rising clk edge with rst_n high.

Structure
REQ-031 A shared package game_pkg holds the cell encodings (EMPTY, P1, P2), the FSM state enum and the direction enum.
REQ-032 Sub-module line_scanner is a parameterised combinational block.
  - Inputs: board, cell coordinates, direction, player.
  - Output: saturated run length.
  - It is instantiated once and time-multiplexed across the 4 CHECK cycles.

Verification
REQ-033 N=3, K=3, first_player=01; P1 plays (0,0),(1,0),(2,0) interleaved with P2 moves -> winner=01 at T+5 after the 5th accepted move; END.
REQ-034 N=3 drawn sequence of 9 moves -> tie=1, winner=00 at T+5 after the 9th move.
REQ-035 N=5, K=4, anti-diagonal win ending at an edge cell (4,0) -> winner set; no false win from wrap-around across rows.
REQ-036 Occupied-cell move, x_in=N, and make_move while busy=1 -> each gives one move_err pulse with board unchanged.
REQ-037 new_game asserted during the second CHECK cycle -> board all 00 and IDLE next cycle; first_player=10 then gives turn=10.
REQ-038 rst_n asserted asynchronously mid-CHECK -> all outputs at reset values before the next clk edge.
